// File: rtl/pc_gen_pkg.sv
// rtl/pc_gen_pkg.sv - shared definitions for the fetch-PC unit
//
// Purpose: transfer-kind codes carried on br_type, the redirect FSM state
//          encoding, and the default reset/exception vectors.
// Ports:   none (package).
// Config:  BRANCH_LIKELY_EN enables decoding of BEQL/BNEL (codes are
//          always defined here so encoders stay stable across builds).
package pc_gen_pkg;

  localparam logic [3:0] BR_NONE = 4'd0;
  localparam logic [3:0] BR_BEQ  = 4'd1;
  localparam logic [3:0] BR_BNE  = 4'd2;
  localparam logic [3:0] BR_BLEZ = 4'd3;
  localparam logic [3:0] BR_BGTZ = 4'd4;
  localparam logic [3:0] BR_BLTZ = 4'd5;
  localparam logic [3:0] BR_BGEZ = 4'd6;
  localparam logic [3:0] BR_J    = 4'd7;
  localparam logic [3:0] BR_JAL  = 4'd8;
  localparam logic [3:0] BR_JR   = 4'd9;
  localparam logic [3:0] BR_JALR = 4'd10;
  localparam logic [3:0] BR_BEQL = 4'd11;
  localparam logic [3:0] BR_BNEL = 4'd12;

  // RUN: no redirect buffered. PEND: a redirect arrived under stall.
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_PEND = 1'b1
  } pc_state_t;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_PC   = 32'h0000_4180;

endpackage

// File: rtl/pc_gen_br_cmp.sv
// rtl/pc_gen_br_cmp.sv - combinational branch condition and target resolver
//
// Purpose: evaluates the D-stage control transfer and produces the redirect
//          target and link address.
// Ports:   br_valid/br_type   - transfer present and its kind
//          rs_val/rt_val      - forwarded comparison operands
//          imm16/index26      - branch offset / jump index
//          pc_d               - PC of the D-stage instruction
//          taken              - transfer redirects fetch
//          redir_tgt          - where fetch goes when taken
//          link_addr          - pc_d + 8
//          flush_ds           - annul delay slot (not-taken branch-likely)
// Config:  BRANCH_LIKELY_EN enables BEQL/BNEL; otherwise they act as NONE
//          and flush_ds is constant 0.
module pc_gen_br_cmp
  import pc_gen_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic            br_valid,
  input  logic [3:0]      br_type,
  input  logic [31:0]     rs_val,
  input  logic [31:0]     rt_val,
  input  logic [15:0]     imm16,
  input  logic [25:0]     index26,
  input  logic [PC_W-1:0] pc_d,
  output logic            taken,
  output logic [PC_W-1:0] redir_tgt,
  output logic [PC_W-1:0] link_addr,
  output logic            flush_ds
);

  logic [PC_W-1:0] pc_d4;
  logic [PC_W-1:0] btgt;
  logic [PC_W-1:0] jtgt;
  logic [PC_W-1:0] rtgt;
  logic            eq;
  logic            rs_neg;
  logic            rs_zero;
  logic            cond;
  logic            likely;

  assign pc_d4     = pc_d + PC_W'(4);
  assign link_addr = pc_d + PC_W'(8);
  assign btgt      = pc_d4 + {{(PC_W-18){imm16[15]}}, imm16, 2'b00};
  // Jump stays within the 256 MB region of the delay slot, not of pc_d.
  assign jtgt      = {pc_d4[PC_W-1:28], index26, 2'b00};
  assign rtgt      = rs_val[PC_W-1:0];

  assign eq      = (rs_val == rt_val);
  assign rs_neg  = rs_val[31];
  assign rs_zero = (rs_val == 32'd0);

  always_comb begin
    cond      = 1'b0;
    likely    = 1'b0;
    redir_tgt = btgt;
    case (br_type)
      BR_BEQ:  cond = eq;
      BR_BNE:  cond = ~eq;
      BR_BLEZ: cond = rs_neg | rs_zero;
      BR_BGTZ: cond = ~rs_neg & ~rs_zero;
      BR_BLTZ: cond = rs_neg;
      BR_BGEZ: cond = ~rs_neg;
      BR_J, BR_JAL: begin
        cond      = 1'b1;
        redir_tgt = jtgt;
      end
      BR_JR, BR_JALR: begin
        cond      = 1'b1;
        redir_tgt = rtgt;
      end
`ifdef BRANCH_LIKELY_EN
      BR_BEQL: begin
        cond   = eq;
        likely = 1'b1;
      end
      BR_BNEL: begin
        cond   = ~eq;
        likely = 1'b1;
      end
`endif
      default: cond = 1'b0;
    endcase
    taken    = br_valid & cond;
    flush_ds = br_valid & likely & ~cond;
  end

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch-PC register with delayed-branch redirect and stall buffering
//
// Purpose: owns the architectural fetch PC; applies exception entry, eret,
//          D-stage redirects and sequential advance; buffers a redirect that
//          arrives while fetch is stalled.
// Ports:   clk, reset (sync, active low)
//          stall              - F holds; D may still resolve a transfer
//          br_valid..pc_d     - D-stage transfer and its operands
//          exc_req/eret_req   - exception entry / return (exc_req wins)
//          epc                - eret return address
//          pc_f               - registered fetch PC
//          taken, link_addr   - D-stage redirect and link value
//          pend               - a redirect is buffered
//          addr_err           - pc_f not word aligned
//          flush_ds           - annul delay slot
// Config:  BRANCH_LIKELY_EN enables BEQL/BNEL and flush_ds.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEF_RESET_PC),
  parameter logic [PC_W-1:0] EXC_PC   = PC_W'(DEF_EXC_PC)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            br_valid,
  input  logic [3:0]      br_type,
  input  logic [31:0]     rs_val,
  input  logic [31:0]     rt_val,
  input  logic [15:0]     imm16,
  input  logic [25:0]     index26,
  input  logic [PC_W-1:0] pc_d,
  input  logic            exc_req,
  input  logic            eret_req,
  input  logic [PC_W-1:0] epc,
  output logic [PC_W-1:0] pc_f,
  output logic            taken,
  output logic [PC_W-1:0] link_addr,
  output logic            pend,
  output logic            addr_err,
  output logic            flush_ds
);

  pc_state_t       state, state_n;
  logic [PC_W-1:0] pend_target, pend_target_n;
  logic [PC_W-1:0] pc_n;
  logic [PC_W-1:0] redir_tgt;

  pc_gen_br_cmp #(.PC_W(PC_W)) u_br_cmp (
    .br_valid  (br_valid),
    .br_type   (br_type),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .imm16     (imm16),
    .index26   (index26),
    .pc_d      (pc_d),
    .taken     (taken),
    .redir_tgt (redir_tgt),
    .link_addr (link_addr),
    .flush_ds  (flush_ds)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_RUN;
      pc_f        <= RESET_PC;
      pend_target <= '0;
    end else begin
      state       <= state_n;
      pc_f        <= pc_n;
      pend_target <= pend_target_n;
    end
  end

  always_comb begin
    state_n       = state;
    pc_n          = pc_f;
    pend_target_n = pend_target;
    if (exc_req) begin
      pc_n    = EXC_PC;
      state_n = ST_RUN;
    end else if (eret_req) begin
      pc_n    = epc;
      state_n = ST_RUN;
    end else begin
      case (state)
        ST_RUN: begin
          if (taken) begin
            if (stall) begin
              pend_target_n = redir_tgt;
              state_n       = ST_PEND;
            end else begin
              pc_n = redir_tgt;
            end
          end else if (!stall) begin
            pc_n = pc_f + PC_W'(4);
          end
        end
        ST_PEND: begin
          if (!stall) begin
            // A redirect resolved in the release cycle is newer than the
            // buffered one, so it takes precedence.
            pc_n    = taken ? redir_tgt : pend_target;
            state_n = ST_RUN;
          end else if (taken) begin
            pend_target_n = redir_tgt;
          end
        end
        default: state_n = ST_RUN;
      endcase
    end
  end

  assign pend     = (state == ST_PEND);
  assign addr_err = |pc_f[1:0];

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - self-checking bench for pc_gen
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        br_valid;
  logic [3:0]  br_type;
  logic [31:0] rs_val, rt_val;
  logic [15:0] imm16;
  logic [25:0] index26;
  logic [31:0] pc_d;
  logic        exc_req, eret_req;
  logic [31:0] epc;
  logic [31:0] pc_f;
  logic        taken;
  logic [31:0] link_addr;
  logic        pend, addr_err, flush_ds;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_pc;
  bit          m_pend;
  logic [31:0] m_tgt;

  always #5 clk = ~clk;

  pc_gen dut (
    .clk(clk), .reset(reset), .stall(stall), .br_valid(br_valid),
    .br_type(br_type), .rs_val(rs_val), .rt_val(rt_val), .imm16(imm16),
    .index26(index26), .pc_d(pc_d), .exc_req(exc_req), .eret_req(eret_req),
    .epc(epc), .pc_f(pc_f), .taken(taken), .link_addr(link_addr),
    .pend(pend), .addr_err(addr_err), .flush_ds(flush_ds)
  );

  function automatic bit ref_cond(input logic [3:0] t, input logic [31:0] rs, input logic [31:0] rt);
    int srs;
    srs = $signed(rs);
    case (t)
      4'd1: return rs == rt;
      4'd2: return rs != rt;
      4'd3: return srs <= 0;
      4'd4: return srs > 0;
      4'd5: return srs < 0;
      4'd6: return srs >= 0;
      4'd7, 4'd8, 4'd9, 4'd10: return 1'b1;
`ifdef BRANCH_LIKELY_EN
      4'd11: return rs == rt;
      4'd12: return rs != rt;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit ref_flush(input bit v, input logic [3:0] t, input logic [31:0] rs, input logic [31:0] rt);
`ifdef BRANCH_LIKELY_EN
    return v && (t == 4'd11 || t == 4'd12) && !ref_cond(t, rs, rt);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] ref_tgt(input logic [3:0] t, input logic [31:0] pcd,
                                          input logic [31:0] rs, input logic [15:0] imm,
                                          input logic [25:0] idx);
    int off;
    off = 4 * $signed({{16{imm[15]}}, imm});
    if (t == 4'd7 || t == 4'd8)
      return ((pcd + 32'd4) & 32'hF000_0000) | ({6'd0, idx} * 32'd4);
    if (t == 4'd9 || t == 4'd10)
      return rs;
    return pcd + 32'd4 + off;
  endfunction

  task automatic idle();
    stall = 0; br_valid = 0; br_type = 4'd0; rs_val = 0; rt_val = 0;
    imm16 = 0; index26 = 0; pc_d = 0; exc_req = 0; eret_req = 0; epc = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle();
    @(posedge clk); #1;
    reset = 1'b1;
    m_pc = 32'h0000_3000; m_pend = 0; m_tgt = 0;
  endtask

  // One clock: check combinational outputs against the model, advance the
  // model by the redirect priority rules, then check the new pc_f.
  task automatic do_cycle(input string tag);
    bit          et, ef;
    logic [31:0] tg;
    #1;
    et = br_valid && ref_cond(br_type, rs_val, rt_val);
    ef = ref_flush(br_valid, br_type, rs_val, rt_val);
    tg = ref_tgt(br_type, pc_d, rs_val, imm16, index26);
    checks++; if (taken !== et) begin errors++; $display("FAIL %s taken: got %0b want %0b", tag, taken, et); end
    checks++; if (flush_ds !== ef) begin errors++; $display("FAIL %s flush_ds: got %0b want %0b", tag, flush_ds, ef); end
    checks++; if (link_addr !== pc_d + 32'd8) begin errors++; $display("FAIL %s link_addr: got %h want %h", tag, link_addr, pc_d + 32'd8); end
    checks++; if (pend !== m_pend) begin errors++; $display("FAIL %s pend: got %0b want %0b", tag, pend, m_pend); end
    checks++; if (addr_err !== (m_pc[1:0] != 2'b00)) begin errors++; $display("FAIL %s addr_err: got %0b pc %h", tag, addr_err, m_pc); end
    if (exc_req) begin
      m_pc = 32'h0000_4180; m_pend = 0;
    end else if (eret_req) begin
      m_pc = epc; m_pend = 0;
    end else if (m_pend) begin
      if (!stall) begin
        m_pc = et ? tg : m_tgt; m_pend = 0;
      end else if (et) m_tgt = tg;
    end else if (et) begin
      if (stall) begin m_pend = 1; m_tgt = tg; end
      else m_pc = tg;
    end else if (!stall) m_pc = m_pc + 32'd4;
    @(posedge clk); #1;
    checks++; if (pc_f !== m_pc) begin errors++; $display("FAIL %s pc_f: got %h want %h", tag, pc_f, m_pc); end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (pc_f !== 32'h0000_3000) begin errors++; $display("FAIL reset pc_f: got %h want 00003000", pc_f); end
    checks++; if (pend !== 1'b0) begin errors++; $display("FAIL reset pend: got %0b want 0", pend); end
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL reset addr_err: got %0b want 0", addr_err); end
    for (int i = 1; i <= 3; i++) begin
      do_cycle("seq");
      checks++; if (pc_f !== 32'h3000 + 32'(4 * i)) begin errors++; $display("FAIL seq%0d pc_f: got %h want %h", i, pc_f, 32'h3000 + 32'(4 * i)); end
    end
  endtask

  task automatic test_branch();
    br_valid = 1; br_type = 4'd1; pc_d = 32'h3004; rs_val = 5; rt_val = 5; imm16 = 16'hFFFF;
    #1;
    checks++; if (taken !== 1'b1) begin errors++; $display("FAIL beq_eq taken: got %0b want 1", taken); end
    do_cycle("beq_eq");
    checks++; if (pc_f !== 32'h3004) begin errors++; $display("FAIL beq_eq pc_f: got %h want 00003004", pc_f); end
    rt_val = 6;
    do_cycle("beq_ne");
    checks++; if (pc_f !== 32'h3008) begin errors++; $display("FAIL beq_ne pc_f: got %h want 00003008", pc_f); end
    br_type = 4'd5; rs_val = 32'h8000_0000; imm16 = 16'h0010;
    #1;
    checks++; if (taken !== 1'b1) begin errors++; $display("FAIL bltz taken: got %0b want 1", taken); end
    do_cycle("bltz");
    br_type = 4'd4; rs_val = 0;
    #1;
    checks++; if (taken !== 1'b0) begin errors++; $display("FAIL bgtz0 taken: got %0b want 0", taken); end
    do_cycle("bgtz0");
    br_type = 4'd8; pc_d = 32'h3010; index26 = 26'h0000C10;
    #1;
    checks++; if (link_addr !== 32'h3018) begin errors++; $display("FAIL jal link_addr: got %h want 00003018", link_addr); end
    do_cycle("jal");
    checks++; if (pc_f !== 32'h3040) begin errors++; $display("FAIL jal pc_f: got %h want 00003040", pc_f); end
    idle();
  endtask

  task automatic test_pend();
    logic [31:0] held;
    held = pc_f;
    stall = 1; br_valid = 1; br_type = 4'd9; rs_val = 32'h5000; pc_d = 32'h3100;
    do_cycle("jr_stall0");
    br_valid = 0;
    do_cycle("jr_stall1");
    do_cycle("jr_stall2");
    checks++; if (pend !== 1'b1 || pc_f !== held) begin errors++; $display("FAIL jr_hold: got pend %0b pc %h want 1 %h", pend, pc_f, held); end
    stall = 0;
    do_cycle("jr_release");
    checks++; if (pc_f !== 32'h5000 || pend !== 1'b0) begin errors++; $display("FAIL jr_release: got pc %h pend %0b want 00005000 0", pc_f, pend); end
    // Reset while pending.
    stall = 1; br_valid = 1;
    do_cycle("pend_for_reset");
    do_reset();
    checks++; if (pc_f !== 32'h3000 || pend !== 1'b0) begin errors++; $display("FAIL reset_mid_pend: got pc %h pend %0b want 00003000 0", pc_f, pend); end
  endtask

  task automatic test_exc();
    stall = 1; br_valid = 1; br_type = 4'd9; rs_val = 32'h6000;
    do_cycle("pend_for_exc");
    br_valid = 0; exc_req = 1;
    do_cycle("exc");
    checks++; if (pc_f !== 32'h4180 || pend !== 1'b0) begin errors++; $display("FAIL exc: got pc %h pend %0b want 00004180 0", pc_f, pend); end
    exc_req = 0; stall = 0; eret_req = 1; epc = 32'h3022;
    do_cycle("eret");
    checks++; if (pc_f !== 32'h3022 || addr_err !== 1'b1) begin errors++; $display("FAIL eret: got pc %h addr_err %0b want 00003022 1", pc_f, addr_err); end
    exc_req = 1;
    do_cycle("exc_and_eret");
    checks++; if (pc_f !== 32'h4180) begin errors++; $display("FAIL exc_and_eret pc_f: got %h want 00004180", pc_f); end
    exc_req = 0; epc = 32'hFFFF_FFFC;
    do_cycle("eret_top");
    eret_req = 0;
    do_cycle("wrap");
    checks++; if (pc_f !== 32'h0) begin errors++; $display("FAIL wrap pc_f: got %h want 00000000", pc_f); end
    idle();
  endtask

  task automatic test_likely();
    bit want_f;
`ifdef BRANCH_LIKELY_EN
    want_f = 1;
`else
    want_f = 0;
`endif
    br_valid = 1; br_type = 4'd12; rs_val = 32'h77; rt_val = 32'h77; pc_d = pc_f - 32'd4; imm16 = 16'h0020;
    #1;
    checks++; if (taken !== 1'b0 || flush_ds !== want_f) begin errors++; $display("FAIL bnel_eq: got taken %0b flush %0b want 0 %0b", taken, flush_ds, want_f); end
    do_cycle("bnel_eq");
    br_type = 4'd11;
    do_cycle("beql_eq");
    br_valid = 0;
    do_cycle("likely_idle");
    idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      stall    = ($urandom_range(0, 9) < 3);
      br_valid = ($urandom_range(0, 9) < 5);
      br_type  = 4'($urandom_range(0, 15));
      rs_val   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) - 32'd1 : $urandom();
      rt_val   = ($urandom_range(0, 2) == 0) ? rs_val : $urandom();
      imm16    = 16'($urandom());
      index26  = 26'($urandom());
      pc_d     = $urandom() & 32'hFFFF_FFFC;
      exc_req  = ($urandom_range(0, 29) == 0);
      eret_req = ($urandom_range(0, 29) == 0);
      epc      = $urandom();
      do_cycle("rand");
    end
    idle();
  endtask

  initial begin
    reset = 1'b0;
    idle();
    test_reset();
    test_branch();
    test_pend();
    test_exc();
    test_likely();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Next-generation fetch-PC unit. Owns the architectural fetch PC register.
- Resolves all MIPS control transfers issued from the D stage with delay-slot semantics: beq/bne/blez/bgtz/bltz/bgez/j/jal/jr/jalr.
- Handles exception entry and eret. Buffers a redirect that arrives while fetch is stalled.
- Sits between the D-stage decoder/comparator operands and the instruction memory address.

Parameters:
- PC_W, 32, PC width; must be >= 30.
- RESET_PC, 32'h0000_3000, fetch PC after reset.
- EXC_PC, 32'h0000_4180, exception entry vector.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- stall  in  1  fetch stall; F holds, D may still resolve.
- br_valid  in  1  D holds a control-transfer instruction this cycle; one-cycle pulse per instruction.
- br_type  in  4  transfer kind; encoding in shared package.
- rs_val  in  32  forwarded rs operand.
- rt_val  in  32  forwarded rt operand.
- imm16  in  16  branch offset.
- index26  in  26  jump index.
- pc_d  in  PC_W  PC of the D-stage instruction.
- exc_req  in  1  take exception.
- eret_req  in  1  return from exception.
- epc  in  PC_W  return address for eret.
- pc_f  out  PC_W  current fetch PC, registered.
- taken  out  1  D-stage transfer redirects; combinational.
- link_addr  out  PC_W  pc_d+8 for jal/jalr.
- pend  out  1  a redirect is buffered.
- addr_err  out  1  pc_f misaligned.
- flush_ds  out  1  annul delay slot; optional feature only.

Behaviour:
- Reset (reset==0 at posedge): pc_f=RESET_PC, pend=0, pend_target=0, state=RUN.
  - Combinational outputs follow their inputs.
  - Reset overrides all requests, including mid-pend.
- Target arithmetic, all mod 2^PC_W:
  - seq = pc_f+4.
  - btgt = pc_d+4+(sext(imm16)<<2).
  - jtgt = {(pc_d+4)[PC_W-1:28], index26, 2'b00}.
  - rtgt = rs_val[PC_W-1:0].
- Conditions: beq rs==rt; bne rs!=rt. blez/bgtz/bltz/bgez compare rs_val signed against 0.
- taken = br_valid & (condition met for branches | 1 for J/JAL/JR/JALR).
- redir_tgt: btgt for branches, jtgt for J/JAL, rtgt for JR/JALR.
- Delay slot: pc_f already equals pc_d+4 when the branch is in D, so a taken redirect loads redir_tgt directly. The delay slot always executes.
- Next-pc_f priority, evaluated at each posedge:
  1. exc_req: pc_f<=EXC_PC. Clears pend. Ignores stall.
  2. eret_req: pc_f<=epc. Clears pend. Ignores stall.
  3. RUN, !stall, taken: pc_f<=redir_tgt.
  4. RUN, stall, taken: pend_target<=redir_tgt, pend<=1, state->PEND. pc_f holds.
  5. PEND, !stall: pc_f<=pend_target, pend<=0, state->RUN. A simultaneous taken in this cycle wins over pend_target (later redirect wins).
  6. PEND, stall, taken: pend_target overwritten. Otherwise hold.
  7. RUN, !stall, !taken: pc_f<=seq. Under stall: hold.
- addr_err = |pc_f[1:0]. pc_f is still presented; downstream raises AdEL.
- exc_req and eret_req both high: exc_req wins.
- Wrap: pc_f=32'hFFFF_FFFC with no redirect -> 32'h0000_0000.

Optional Feature:
- Macro: BRANCH_LIKELY_EN.
- Defined:
  - br_type codes BEQL and BNEL are decoded with beq/bne conditions.
  - Taken: behaves as a normal branch.
  - Not taken: flush_ds=1 for that cycle (combinational, requires br_valid) to annul the delay slot in F. pc_f advances normally.
- Undefined: BEQL/BNEL behave as NONE (taken=0), and flush_ds is tied 0.

Decomposition:
- Package pc_gen_pkg holds:
  - br_type localparams: NONE=0, BEQ=1, BNE=2, BLEZ=3, BGTZ=4, BLTZ=5, BGEZ=6, J=7, JAL=8, JR=9, JALR=10, BEQL=11, BNEL=12.
  - State encoding RUN/PEND.
  - Default RESET_PC and EXC_PC.
- One natural sub-module: br_cmp, the combinational condition/target resolver. pc_gen keeps the PC register, pend buffer and priority mux.

Test Plan:
- Reset then 3 cycles no stall -> pc_f 0x3000, 0x3004, 0x3008, 0x300C; addr_err=0.
- pc_d=0x3004, BEQ, rs=rt=5, imm16=0xFFFF -> taken=1; next pc_f=0x3004. Same with rt=6 -> taken=0, pc_f=seq.
- BLTZ with rs=0x8000_0000 -> taken. BGTZ with rs=0 -> not taken. JAL with pc_d=0x3010, index26=0x0000C10 -> pc_f=0x0000_3040, link_addr=0x3018.
- JR (rs=0x5000) with stall=1 for 3 cycles -> pend=1 and pc_f holds; first cycle after stall drops -> pc_f=0x5000, pend=0.
- Pending redirect plus exc_req -> pc_f=0x4180, pend=0. Next, eret_req with epc=0x3022 -> pc_f=0x3022, addr_err=1.
- (BRANCH_LIKELY_EN) BNEL, rs=rt -> taken=0, flush_ds=1. Macro undefined -> taken=0, flush_ds=0.
